// File: rtl/edge_pkg.sv
// Shared edge labels, gating-mode encodings and the mode decode used by the
// adaptive hysteresis edge classifier.
package edge_pkg;

  typedef logic [1:0] edge_t;

  localparam edge_t EDGE_STRONG = 2'b10;
  localparam edge_t EDGE_WEAK   = 2'b01;
  localparam edge_t EDGE_NONE   = 2'b00;

  localparam logic [1:0] MODE_FIXED  = 2'b00;
  localparam logic [1:0] MODE_MEAN   = 2'b01;
  localparam logic [1:0] MODE_OFFSET = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Reserved mode falls back to the ungated behaviour of MODE_FIXED.
  function automatic logic mode_gated(input logic [1:0] mode);
    logic gated;
    case (mode)
      MODE_MEAN, MODE_OFFSET: gated = 1'b1;
      MODE_FIXED, MODE_RSVD:  gated = 1'b0;
      default:                gated = 1'b0;
    endcase
    return gated;
  endfunction

endpackage

// File: rtl/adaptive_edge_classifier_window_sum.sv
// Two-stage registered adder tree: pairwise partial sums at S1, exact
// neighbourhood total at S2. Both stages hold while en_i is low.
module window_sum #(
  parameter int DATA_W = 8,
  parameter int N_TAPS = 9
) (
  input  logic                               clk,
  input  logic                               en_i,
  input  logic [N_TAPS*DATA_W-1:0]           win_i,
  output logic [DATA_W+$clog2(N_TAPS)-1:0]   sum_o
);

  localparam int SUM_W   = DATA_W + $clog2(N_TAPS);
  localparam int N_PAIRS = (N_TAPS + 1) / 2;
  localparam int PAIR_W  = DATA_W + 1;

  logic [PAIR_W-1:0] pair_d [N_PAIRS];
  logic [PAIR_W-1:0] pair_q [N_PAIRS];
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    if (2 * p + 1 < N_TAPS) begin : g_two
      assign pair_d[p] = PAIR_W'(win_i[2*p*DATA_W +: DATA_W])
                       + PAIR_W'(win_i[(2*p+1)*DATA_W +: DATA_W]);
    end else begin : g_one
      assign pair_d[p] = PAIR_W'(win_i[2*p*DATA_W +: DATA_W]);
    end
  end

  // NOTE: pure datapath registers carry no reset; the stage valids in the top
  // decide whether their contents mean anything, and skipping reset keeps them cheap.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int p = 0; p < N_PAIRS; p++) pair_q[p] <= pair_d[p];
    end
  end

  // NOTE: the accumulator is combinational, so it is seeded with a default
  // first and built with blocking assignments; no latch can be inferred.
  always_comb begin
    sum_d = '0;
    for (int p = 0; p < N_PAIRS; p++) sum_d = sum_d + SUM_W'(pair_q[p]);
  end

  always_ff @(posedge clk) begin
    if (en_i) sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/adaptive_edge_classifier.sv
// Canny hysteresis edge classifier: labels each NMS pixel strong/weak/none
// against runtime thresholds with optional local-mean gating, 3-stage pipeline.
module adaptive_edge_classifier
  import edge_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_TAPS   = 9,
  parameter int CNT_W    = 24,
  parameter int HIGH_DEF = 155,
  parameter int LOW_DEF  = 130
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         din,
  input  logic [N_TAPS*DATA_W-1:0]  win,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_W-1:0]         cfg_high,
  input  logic [DATA_W-1:0]         cfg_low,
  input  logic [DATA_W-1:0]         cfg_offset,
  input  logic                      stat_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output edge_t                     edge_type,
  output logic [CNT_W-1:0]          strong_count,
  output logic [CNT_W-1:0]          weak_count
);

  localparam int               SUM_W = DATA_W + $clog2(N_TAPS);
  localparam logic [SUM_W-1:0] NT    = SUM_W'(N_TAPS);

  logic              en;
  logic [DATA_W-1:0] high_q, low_q, off_q;
  logic [1:0]        mode_q;

  logic              v1_q;
  logic [DATA_W-1:0] din1_q, high1_q, low1_q, off1_q;
  logic [1:0]        mode1_q;

  logic              v2_q;
  logic [DATA_W-1:0] din2_q, high2_q, low2_q;
  logic [1:0]        mode2_q;
  logic [SUM_W-1:0]  dinx2_q, offx2_q, sum2;

  logic              gate;
  edge_t             class_d;
  logic              out_valid_q;
  edge_t             edge_q;
  logic              strong_hit, weak_hit;
  logic [CNT_W-1:0]  strong_q, weak_q;

  // The whole pipeline advances together, so stalls never collapse bubbles.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_q <= DATA_W'(HIGH_DEF);
      low_q  <= DATA_W'(LOW_DEF);
      mode_q <= MODE_MEAN;
      off_q  <= '0;
    end else if (cfg_we) begin
      high_q <= cfg_high;
      low_q  <= cfg_low;
      mode_q <= cfg_mode;
      off_q  <= cfg_offset;
    end
  end

  // S1: centre pixel plus a snapshot of the config it must be judged with.
  always_ff @(posedge clk) begin
    if (rst)     v1_q <= 1'b0;
    else if (en) v1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      din1_q  <= din;
      high1_q <= high_q;
      low1_q  <= low_q;
      mode1_q <= mode_q;
      off1_q  <= off_q;
    end
  end

  window_sum #(
    .DATA_W (DATA_W),
    .N_TAPS (N_TAPS)
  ) u_window_sum (
    .clk   (clk),
    .en_i  (en),
    .win_i (win),
    .sum_o (sum2)
  );

  // S2: scale both sides of the mean comparison by N_TAPS to avoid a divider.
  always_ff @(posedge clk) begin
    if (rst)     v2_q <= 1'b0;
    else if (en) v2_q <= v1_q;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      din2_q  <= din1_q;
      high2_q <= high1_q;
      low2_q  <= low1_q;
      mode2_q <= mode1_q;
      dinx2_q <= SUM_W'(din1_q) * NT;
      offx2_q <= (mode1_q == MODE_OFFSET) ? SUM_W'(off1_q) * NT : '0;
    end
  end

  always_comb begin
    gate    = !mode_gated(mode2_q)
              || ({1'b0, dinx2_q} >= ({1'b0, sum2} + {1'b0, offx2_q}));
    class_d = EDGE_NONE;
    if (gate && din2_q >= high2_q)     class_d = EDGE_STRONG;
    else if (gate && din2_q >= low2_q) class_d = EDGE_WEAK;
  end

  // S3: result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      edge_q      <= EDGE_NONE;
    end else if (en) begin
      out_valid_q <= v2_q;
      edge_q      <= v2_q ? class_d : EDGE_NONE;
    end
  end

  assign strong_hit = out_valid_q && out_ready && (edge_q == EDGE_STRONG);
  assign weak_hit   = out_valid_q && out_ready && (edge_q == EDGE_WEAK);

  // A clear still counts the transfer happening in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                              strong_q <= '0;
    else if (stat_clr)                    strong_q <= CNT_W'(strong_hit);
    else if (strong_hit && strong_q != '1) strong_q <= strong_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                            weak_q <= '0;
    else if (stat_clr)                  weak_q <= CNT_W'(weak_hit);
    else if (weak_hit && weak_q != '1)  weak_q <= weak_q + CNT_W'(1);
  end

  assign out_valid    = out_valid_q;
  assign edge_type    = edge_q;
  assign strong_count = strong_q;
  assign weak_count   = weak_q;

endmodule
